// File: rtl/button_step_gen.sv
// Push-button front end: two-flop synchronizer, debounce FSM and auto-repeat,
// producing one qualified step pulse per accepted press or repeat.
//
// state       | meaning
// IDLE        | button released and stable
// DEB_PRESS   | b_s high, waiting for DEBOUNCE_CYCLES of stability
// HELD        | press accepted, repeat timer running
// DEB_RELEASE | b_s low, waiting for DEBOUNCE_CYCLES of stability
module button_step_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic       we,
  output logic       step,
  output logic       pressed,
  output logic [7:0] step_count
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST   = CNT_W'(REPEAT_PERIOD - 1);
  localparam bit               RPT_EN     = (REPEAT_DELAY != 0);

  logic             s1, b_s;
  state_t           state, state_n;
  logic [CNT_W-1:0] dcnt, dcnt_n;
  logic [CNT_W-1:0] rcnt, rcnt_n;
  logic [CNT_W-1:0] r_lim;
  logic             rep, rep_n;
  logic             pressed_n;
  logic             step_due;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 1'b0;
      b_s        <= 1'b0;
      state      <= IDLE;
      dcnt       <= '0;
      rcnt       <= '0;
      rep        <= 1'b0;
      step       <= 1'b0;
      pressed    <= 1'b0;
      step_count <= 8'd0;
    end else begin
      s1      <= button;
      b_s     <= s1;
      state   <= state_n;
      dcnt    <= dcnt_n;
      rcnt    <= rcnt_n;
      rep     <= rep_n;
      pressed <= pressed_n;
      // A due step with we low is dropped outright, never queued.
      step    <= step_due & we;
      if (step_due && we)
        step_count <= step_count + 8'd1;
    end
  end

  assign r_lim = rep ? PER_LAST : DELAY_LAST;

  always_comb begin
    state_n   = state;
    dcnt_n    = dcnt;
    rcnt_n    = rcnt;
    rep_n     = rep;
    pressed_n = pressed;
    step_due  = 1'b0;
    case (state)
      IDLE: begin
        if (b_s) begin
          state_n = DEB_PRESS;
          dcnt_n  = '0;
        end
      end
      DEB_PRESS: begin
        if (!b_s) begin
          state_n = IDLE;
        end else if (dcnt == DEB_LAST) begin
          state_n   = HELD;
          pressed_n = 1'b1;
          rcnt_n    = '0;
          rep_n     = 1'b0;
          step_due  = 1'b1;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      HELD: begin
        // Release wins over a repeat falling due in the same cycle.
        if (!b_s) begin
          state_n = DEB_RELEASE;
          dcnt_n  = '0;
        end else if (!RPT_EN) begin
          rcnt_n = '0;
        end else if (rcnt == r_lim) begin
          step_due = 1'b1;
          rcnt_n   = '0;
          rep_n    = 1'b1;
        end else begin
          rcnt_n = rcnt + 1'b1;
        end
      end
      DEB_RELEASE: begin
        // Bounce back to HELD keeps rcnt/rep frozen so the repeat phase survives.
        if (b_s) begin
          state_n = HELD;
        end else if (dcnt == DEB_LAST) begin
          state_n   = IDLE;
          pressed_n = 1'b0;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_button_step_gen.sv
// Directed bench for button_step_gen with short timing parameters; a second
// instance has auto-repeat disabled.
module tb_button_step_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button = 1'b0;
  logic       button0 = 1'b0;
  logic       we = 1'b1;
  logic       step, pressed;
  logic [7:0] step_count;
  logic       step0, pressed0;
  logic [7:0] step_count0;

  int total = 0;
  int bad = 0;
  int seen;

  always #5 clk = ~clk;

  button_step_gen #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .button(button), .we(we),
    .step(step), .pressed(pressed), .step_count(step_count)
  );

  button_step_gen #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3), .CNT_W(8)
  ) dut0 (
    .clk(clk), .rst(rst), .button(button0), .we(we),
    .step(step0), .pressed(pressed0), .step_count(step_count0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset with button held, then first press after release of reset
    button = 1'b1;
    we = 1'b1;
    rst = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("rst_step", step, 0);
      chk("rst_pressed", pressed, 0);
      chk("rst_count", step_count, 0);
    end
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("post_rst_step", step, (e == 7));
      chk("post_rst_pressed", pressed, (e >= 7));
    end
    chk("post_rst_count", step_count, 1);

    // Reset mid-operation, button still held: re-debounced, new step
    rst = 1'b1;
    tick();
    chk("midrst_step", step, 0);
    chk("midrst_pressed", pressed, 0);
    chk("midrst_count", step_count, 0);
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk("midrst_re_step", step, (e == 7));
    end

    // Clean press: high sampled at edges 1-14
    button = 1'b0;
    do_reset(2);
    repeat (3) tick();
    button = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      tick();
      chk("clean_step", step, (e == 7 || e == 15));
      chk("clean_pressed", pressed, (e >= 7 && e < 21));
      if (e == 14) button = 1'b0;
    end
    chk("clean_count", step_count, 2);

    // Bounce 1,1,0: never stable for 4 cycles
    for (int e = 0; e < 30; e++) begin
      button = (e % 3 != 2);
      tick();
      chk("bounce_step", step, 0);
      chk("bounce_pressed", pressed, 0);
    end
    button = 1'b0;
    repeat (4) tick();
    chk("bounce_count", step_count, 2);

    // Enable gating: first step dropped, repeat at edge 15 taken
    do_reset(2);
    we = 1'b0;
    button = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      chk("gate_step", step, (e == 15));
      chk("gate_pressed", pressed, (e >= 7));
      if (e == 7) begin
        chk("gate_count7", step_count, 0);
        we = 1'b1;
      end
    end
    chk("gate_count15", step_count, 1);
    button = 1'b0;

    // Repeat disabled: one step only over 100 held cycles
    do_reset(2);
    button0 = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      tick();
      chk("norep_step", step0, (e == 7));
    end
    chk("norep_count", step_count0, 1);
    chk("norep_pressed", pressed0, 1);
    button0 = 1'b0;

    // 256 clean presses wrap step_count
    do_reset(2);
    seen = 0;
    for (int p = 0; p < 256; p++) begin
      button = 1'b1;
      repeat (8) begin
        tick();
        if (step) seen++;
      end
      button = 1'b0;
      repeat (10) begin
        tick();
        if (step) seen++;
      end
      if (p == 254) chk("wrap_count255", step_count, 255);
    end
    chk("wrap_seen", seen, 256);
    chk("wrap_count0", step_count, 0);
    chk("wrap_pressed", pressed, 0);

    // 2-cycle low glitch while held: pressed stays, rcnt frozen 3 cycles
    button = 1'b1;
    for (int e = 1; e <= 28; e++) begin
      tick();
      chk("glitch_step", step, (e == 7 || e == 15 || e == 18 || e == 24 || e == 27));
      chk("glitch_pressed", pressed, (e >= 7));
      if (e == 18) button = 1'b0;
      if (e == 20) button = 1'b1;
    end
    chk("glitch_count", step_count, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_step_gen.md
# button_step_gen

Button front-end for the LED stepper. Synchronizes and debounces a raw push-button and produces a registered single-cycle `step` pulse per accepted press, with optional auto-repeat while the button is held. It also provides a debounced `pressed` level and a wrapping count of emitted steps. `step` feeds the stepper's advance condition directly; the `we` gating is applied here, so the stepper sees only qualified pulses.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: cycles the synchronized input must be stable before a press or release is accepted; minimum 1.
- `REPEAT_DELAY`, default 25000000: cycles in the held state before the first auto-repeat step; 0 disables auto-repeat.
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent auto-repeat steps; minimum 1.
- `CNT_W`, default 26: width of the internal timers; every cycle parameter must be below 2^CNT_W.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `button` input 1: raw, asynchronous, bouncing button level; 1 = pressed.
- `we` input 1: step enable, sampled in the cycle a step is due.
- `step` output 1: registered one-cycle pulse per accepted press or repeat.
- `pressed` output 1: registered debounced button level.
- `step_count` output 8: number of emitted steps, modulo 256.

## Operation
- Synchronizer: two flops `button` -> `s1` -> `b_s`. The FSM uses only `b_s`.
- FSM states:
  - IDLE: if `b_s`=1, go to DEB_PRESS and set `dcnt`=0.
  - DEB_PRESS: if `b_s`=0, go to IDLE. Otherwise, if `dcnt`==DEBOUNCE_CYCLES-1, go to HELD, set `pressed`=1, set `rcnt`=0, and issue a step. Otherwise increment `dcnt`.
  - HELD: if `b_s`=0, go to DEB_RELEASE and set `dcnt`=0. Release has priority over a due repeat; no step is issued in that cycle. Otherwise run the repeat logic.
  - DEB_RELEASE: if `b_s`=1, return to HELD. `rcnt` and the repeat phase are kept frozen, not reset. If `dcnt`==DEBOUNCE_CYCLES-1 with `b_s`=0, go to IDLE and set `pressed`=0. Otherwise increment `dcnt`.
- Repeat logic (HELD only, REPEAT_DELAY != 0):
  - Phase flag `rep` is cleared on HELD entry from DEB_PRESS.
  - Limit L = REPEAT_DELAY-1 when `rep`=0, or REPEAT_PERIOD-1 when `rep`=1.
  - When `rcnt`==L: issue a step, set `rcnt`=0, set `rep`=1. Otherwise increment `rcnt`.
  - With REPEAT_DELAY = 0, `rcnt` is held at 0 and no repeats are issued.
- Issue a step:
  - If `we`=1 in that cycle: `step`=1 on the next edge and `step_count` increments (wraps 255 -> 0).
  - If `we`=0: the event is dropped, not queued. The FSM transitions and timers advance identically.
- `step` is 0 in every other cycle.
- Counter arithmetic: `dcnt` and `rcnt` are CNT_W unsigned; equality compares only, no overflow path.

## Timing
- Reset values: `s1`=0, `b_s`=0, state IDLE, `dcnt`=0, `rcnt`=0, `rep`=0, `step`=0, `pressed`=0, `step_count`=0.
- Reset mid-operation: everything returns to reset values on the next edge. A button still held after reset is re-synchronized and re-debounced from scratch, and produces a new step.
- Press latency: number edges so that edge 1 is the first edge sampling `button`=1, with the button held. `step` and `pressed` are high after edge DEBOUNCE_CYCLES+3.
- Repeats: with HELD entered at edge T, repeat steps occur at edges T+REPEAT_DELAY, then every REPEAT_PERIOD after that, while `b_s` stays high.
- Release latency: number edges so that edge 1 is the first edge sampling `button`=0. `pressed` falls after edge DEBOUNCE_CYCLES+3.
- Any `b_s` glitch shorter than DEBOUNCE_CYCLES returns the FSM to its prior stable state.
- `step` and `pressed` never change in the same cycle as the raw input.

## Test plan
Overrides: DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, CNT_W=8.
- Reset: `rst`=1 for 3 cycles with `button`=1 -> `step`, `pressed`, `step_count` all 0; after release, first step after edge 7.
- Clean press: `button` high sampled at edges 1-14, `we`=1 -> steps after edges 7 and 15 only, `pressed` falls after edge 21, `step_count`=2.
- Bounce: `button` toggles 1,1,0 repeatedly for 30 cycles -> `step`=0, `pressed`=0 throughout.
- Enable gating: `we`=0 through edge 7, then 1; button held -> no step at edge 7, `pressed`=1 at edge 7, step at edge 15, `step_count`=1.
- No repeat: REPEAT_DELAY=0, button held 100 cycles -> exactly one step after edge 7.
- Wrap and release bounce: 256 clean presses -> `step_count` wraps to 0. A 2-cycle low glitch while held -> `pressed` stays 1 and the repeat timing is unshifted.
